// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: reset bridge, minimum-width stretch, then staggered per-channel release.
// Optional RST_SEQ_EVT_CNT_EN adds rst_cnt_o, a saturating count of completed sequences.
//
// state   | meaning
// --------+--------------------------------------------------------------
// HOLD    | bridge just released; all channels asserted, soft requests ignored
// STRETCH | all channels asserted, counting the minimum reset width
// RELEASE | channels released one at a time, STAGGER_CYCLES apart
// RUN     | every channel released; waiting for a soft request
module rst_seq_ctrl #(
    parameter int NUM_CH         = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic              aclk_i,
    input  logic              areset_n_i,
    input  logic              sw_rst_req_i,
    output logic              aclk_o,
    output logic [NUM_CH-1:0] areset_n_o,
    output logic              rst_busy_o,
    output logic              rst_done_o
`ifdef RST_SEQ_EVT_CNT_EN
    ,
    output logic [7:0]        rst_cnt_o
`endif
);

    localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Load values are one less than the wait, since the releasing edge is the one that sees zero.
    localparam logic [CW-1:0]     STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0]     STAGGER_LOAD = CW'(STAGGER_CYCLES - 1);
    localparam logic [NUM_CH-1:0] CH_ONE       = NUM_CH'(1);
    localparam logic [NUM_CH-1:0] CH_ALL       = '1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync_n;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] rel_next;
    logic              cnt_zero;

    assign aclk_o = aclk_i;

    always_ff @(posedge aclk_i or negedge areset_n_i) begin
        if (!areset_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

    // Thermometer step: releases the lowest still-asserted channel.
    assign rel_next = (rst_q << 1) | CH_ONE;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        done_d  = 1'b0;

        case (state_q)
            HOLD: begin
                state_d = STRETCH;
                cnt_d   = STRETCH_LOAD;
                rst_d   = '0;
            end
            STRETCH, RELEASE: begin
                if (cnt_zero) begin
                    rst_d = rel_next;
                    cnt_d = STAGGER_LOAD;
                    if (rel_next == CH_ALL) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                rst_d   = '0;
            end
        endcase

        // A soft request overrides everything, including a final release on the same edge.
        if (sw_rst_req_i && (state_q != HOLD)) begin
            state_d = STRETCH;
            cnt_d   = STRETCH_LOAD;
            rst_d   = '0;
            done_d  = 1'b0;
        end

        busy_d = ~(&rst_d);
    end

    always_ff @(posedge aclk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rst_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign areset_n_o = rst_q;
    assign rst_busy_o = busy_q;
    assign rst_done_o = done_q;

`ifdef RST_SEQ_EVT_CNT_EN
    logic [7:0] evt_cnt_q, evt_cnt_d;

    // Counts on the same edge the done pulse is launched, so both appear together.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (done_d && (evt_cnt_q != 8'hFF)) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge aclk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign rst_cnt_o = evt_cnt_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Randomised bench for rst_seq_ctrl: a release-time model predicts every output each cycle.
// Covers a default instance and a single-channel instance (SYNC_STAGES=3, STRETCH_CYCLES=1).
module tb_rst_seq_ctrl;

    localparam int NCH  = 3;
    localparam int SYNC = 2;
    localparam int STR  = 16;
    localparam int STG  = 4;
    localparam int INIT_ANCHOR = SYNC + STR;
    localparam int ANCHOR1     = 3 + 1;

    logic       aclk_i;
    logic       areset_n_i;
    logic       sw_rst_req_i;
    logic       aclk_o;
    logic [2:0] areset_n_o;
    logic       rst_busy_o;
    logic       rst_done_o;
    logic       aclk1;
    logic [0:0] areset_n1;
    logic       busy1;
    logic       done1;
`ifdef RST_SEQ_EVT_CNT_EN
    logic [7:0] rst_cnt_o;
    logic [7:0] rst_cnt1;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Model: n is the edge index since E0 (-1 while in reset); bit k releases after edge anchor + k*STG.
    int n      = -1;
    int anchor = INIT_ANCHOR;
    int evt0   = 0;
    int evt1   = 0;

    rst_seq_ctrl dut (
        .aclk_i      (aclk_i),
        .areset_n_i  (areset_n_i),
        .sw_rst_req_i(sw_rst_req_i),
        .aclk_o      (aclk_o),
        .areset_n_o  (areset_n_o),
        .rst_busy_o  (rst_busy_o),
        .rst_done_o  (rst_done_o)
`ifdef RST_SEQ_EVT_CNT_EN
        ,
        .rst_cnt_o   (rst_cnt_o)
`endif
    );

    rst_seq_ctrl #(
        .NUM_CH        (1),
        .SYNC_STAGES   (3),
        .STRETCH_CYCLES(1),
        .STAGGER_CYCLES(4)
    ) dut1 (
        .aclk_i      (aclk_i),
        .areset_n_i  (areset_n_i),
        .sw_rst_req_i(1'b0),
        .aclk_o      (aclk1),
        .areset_n_o  (areset_n1),
        .rst_busy_o  (busy1),
        .rst_done_o  (done1)
`ifdef RST_SEQ_EVT_CNT_EN
        ,
        .rst_cnt_o   (rst_cnt1)
`endif
    );

    initial begin
        aclk_i = 1'b0;
        forever #5 aclk_i = ~aclk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (edge %0d)", tag, obs, exp, $time, n);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic compare();
        logic [2:0] eb;
        logic       eb1;
        for (int k = 0; k < NCH; k++) begin
            eb[k] = (n >= anchor + k * STG);
        end
        eb1 = (n >= ANCHOR1);
        check("areset_n_o", 32'(areset_n_o), 32'(eb));
        check("rst_busy_o", 32'(rst_busy_o), 32'(!(&eb)));
        check("rst_done_o", 32'(rst_done_o), 32'(n == anchor + (NCH - 1) * STG));
        check("ch1_areset_n_o", 32'(areset_n1), 32'(eb1));
        check("ch1_busy", 32'(busy1), 32'(!eb1));
        check("ch1_done", 32'(done1), 32'(n == ANCHOR1));
`ifdef RST_SEQ_EVT_CNT_EN
        check("rst_cnt_o", 32'(rst_cnt_o), 32'(evt0));
        check("ch1_rst_cnt_o", 32'(rst_cnt1), 32'(evt1));
`endif
    endtask

    // Called just after an active edge; drives the request, advances one edge, then checks.
    task automatic step(input bit req);
        sw_rst_req_i = req;
        @(posedge aclk_i);
        if (areset_n_i) begin
            n++;
            if (req && n > SYNC) anchor = n + STR;
            if (n == anchor + (NCH - 1) * STG) evt0 = sat_inc(evt0);
            if (n == ANCHOR1) evt1 = sat_inc(evt1);
        end
        #1;
        compare();
    endtask

    task automatic async_drop();
        #2;
        areset_n_i = 1'b0;
        n      = -1;
        anchor = INIT_ANCHOR;
        evt0   = 0;
        evt1   = 0;
        #1;
        compare();
    endtask

    task automatic release_rst();
        areset_n_i = 1'b1;
    endtask

    initial begin
        int g;
        areset_n_i   = 1'b1;
        sw_rst_req_i = 1'b0;
        // Fill the bridges so the following drop produces a clean reset event.
        repeat (5) @(posedge aclk_i);
        #1;
        async_drop();
        repeat (3) step(1'b0);

        #1;
        check("aclk_o_high", 32'(aclk_o), 32'(aclk_i));
        check("ch1_aclk_o_high", 32'(aclk1), 32'(aclk_i));
        #5;
        check("aclk_o_low", 32'(aclk_o), 32'(aclk_i));
        @(posedge aclk_i);
        #1;

        // Power-on sequence: release before E0.
        release_rst();
        repeat (32) step(1'b0);

        // One-cycle soft reset in RUN.
        step(1'b1);
        repeat (30) step(1'b0);

        // Held request while bit 0 is released but bit 1 is not.
        step(1'b1);
        g = 0;
        while (n < anchor && g < 100) begin
            step(1'b0);
            g++;
        end
        check("held_setup_reached", 32'(n >= anchor && n < anchor + STG), 32'(1));
        repeat (10) step(1'b1);
        repeat (30) step(1'b0);

        // Async abort mid-STRETCH, then 2 cycles after bit 1 releases.
        async_drop();
        step(1'b0);
        release_rst();
        repeat (10) step(1'b0);
        async_drop();
        step(1'b0);
        release_rst();
        g = 0;
        while (n < anchor + STG + 2 && g < 100) begin
            step(1'b0);
            g++;
        end
        check("abort2_setup_reached", 32'(n), 32'(anchor + STG + 2));
        async_drop();
        repeat (2) step(1'b0);
        release_rst();
        repeat (30) step(1'b0);

        // Collision: request sampled on the edge that releases the last channel.
        step(1'b1);
        g = 0;
        while (n + 1 < anchor + (NCH - 1) * STG && g < 100) begin
            step(1'b0);
            g++;
        end
        check("collision_setup_reached", 32'(n + 1), 32'(anchor + (NCH - 1) * STG));
        step(1'b1);
        repeat (30) step(1'b0);

        // Random mix of soft requests and async aborts.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                async_drop();
                repeat (int'($urandom_range(0, 2))) step(1'b0);
                release_rst();
            end else begin
                step(r < 8);
            end
        end
        repeat (30) step(1'b0);

`ifdef RST_SEQ_EVT_CNT_EN
        async_drop();
        step(1'b0);
        release_rst();
        repeat (30) step(1'b0);
        for (int i = 0; i < 257; i++) begin
            step(1'b1);
            repeat (26) step(1'b0);
        end
        check("evt_saturated", 32'(rst_cnt_o), 32'(255));
        async_drop();
        check("evt_cleared", 32'(rst_cnt_o), 32'(0));
        release_rst();
        repeat (30) step(1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
